// File: rtl/regfile_dump_reader.sv
// Sweeps a contiguous (wrapping) range of register-file entries and streams
// them out over a valid/ready port, reading two registers per fetch through
// the file's two combinational read ports.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  lo_reg,
  input  logic [SEL_WIDTH-1:0]  hi_reg,
  output logic [SEL_WIDTH-1:0]  regsel_source0,
  output logic [SEL_WIDTH-1:0]  regsel_source1,
  input  logic [DATA_WIDTH-1:0] dataout0,
  input  logic [DATA_WIDTH-1:0] dataout1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND0, SEND1} state_t;

  state_t                state, state_nxt;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH:0]    remaining;   // one extra bit: a full sweep holds 2^SEL_WIDTH
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic                  done_q;

  logic [SEL_WIDTH-1:0]  span;
  logic [SEL_WIDTH-1:0]  ptr_p1;
  logic                  xfer;
  logic                  is_last;

  assign span    = hi_reg - lo_reg;                 // natural wrap gives the mod
  assign ptr_p1  = ptr + SEL_WIDTH'(1);
  assign is_last = (remaining == (SEL_WIDTH+1)'(1));
  assign xfer    = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a sweep ends on whichever word carries the last count
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = SEND0;
      SEND0: if (xfer) state_nxt = is_last ? IDLE : SEND1;
      SEND1: if (xfer) state_nxt = is_last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; payload is forced to zero whenever no word is offered
  always_comb begin
    regsel_source0 = '0;
    regsel_source1 = '0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_index      = '0;
    out_last       = 1'b0;
    case (state)
      FETCH: begin
        regsel_source0 = ptr;
        regsel_source1 = ptr_p1;
      end
      SEND0: begin
        out_valid = 1'b1;
        out_data  = buf0;
        out_index = ptr;
        out_last  = is_last;
      end
      SEND1: begin
        out_valid = 1'b1;
        out_data  = buf1;
        out_index = ptr_p1;
        out_last  = is_last;
      end
      default: ;
    endcase
    busy = (state != IDLE);
    done = done_q;
  end

  // Sweep pointer, word count, read-data capture and the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      buf0      <= '0;
      buf1      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= xfer && is_last;
      if (state == IDLE && start) begin
        ptr       <= lo_reg;
        remaining <= {1'b0, span} + (SEL_WIDTH+1)'(1);
      end
      if (state == FETCH) begin
        buf0 <= dataout0;
        buf1 <= dataout1;
      end
      if (xfer) begin
        remaining <= remaining - (SEL_WIDTH+1)'(1);
        if (state == SEND1 && !is_last) ptr <= ptr + SEL_WIDTH'(2);
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: issued sweeps push expected words, a negedge monitor
// pops and compares every accepted word, watches stall stability and done.
module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] lo_reg, hi_reg;
  logic [SW-1:0] regsel_source0, regsel_source1;
  logic [DW-1:0] dataout0, dataout1;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_index;
  logic          out_last, busy, done;

  logic [DW-1:0] regs [16];

  assign dataout0 = regs[regsel_source0];
  assign dataout1 = regs[regsel_source1];

  regfile_dump_reader #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(rst), .start(start), .lo_reg(lo_reg), .hi_reg(hi_reg),
    .regsel_source0(regsel_source0), .regsel_source1(regsel_source1),
    .dataout0(dataout0), .dataout1(dataout1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   exp_done   = 0;
  bit   stall_prev = 0;
  logic [DW-1:0] held_d;
  logic [SW-1:0] held_i;
  logic          held_l;

  int       rdy_mode = 0;   // 0: always ready, 1: random, 2: 1,0,0,1 pattern
  int       pidx = 0;
  bit [3:0] pat = 4'b1001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = pat[3 - (pidx % 4)];
        pidx++;
      end
    endcase
  end

  // Monitor: compares accepted words against the scoreboard queue
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(held_d));
        chk("stall_index", 64'(out_index), 64'(held_i));
        chk("stall_last", 64'(out_last), 64'(held_l));
      end
      if (exp_done) begin
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        exp_done = 0;
      end else if (done) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 64'(out_index), 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", 64'(out_data), 64'(e.d));
          chk("word_index", 64'(out_index), 64'(e.idx));
          chk("word_last", 64'(out_last), 64'(e.last));
          if (e.last) exp_done = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_i = out_index;
      held_l = out_last;
    end
  end

  // Reference model: the list of registers a sweep visits, in order
  task automatic push_sweep(input int lo, input int hi);
    int n;
    n = ((hi - lo + 16) % 16) + 1;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.idx  = SW'((lo + k) % 16);
      e.d    = regs[(lo + k) % 16];
      e.last = (k == n - 1);
      q.push_back(e);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the FETCH cycle
  task automatic issue(input int lo, input int hi);
    lo_reg = SW'(lo);
    hi_reg = SW'(hi);
    start  = 1'b1;
    push_sweep(lo, hi);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // First word must appear two cycles after start
  task automatic chk_latency();
    chk("lat_fetch_valid", 64'(out_valid), 64'(0));
    chk("lat_fetch_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    chk("lat_send0_valid", 64'(out_valid), 64'(1));
  endtask

  // Returns at posedge+1 of the done cycle
  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lo_reg = '0; hi_reg = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = DW'(100 + i);
    #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_sel0", 64'(regsel_source0), 64'(0));
    chk("rst_sel1", 64'(regsel_source1), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Full sweep 0..15
    issue(0, 15);
    chk_latency();
    wait_done();

    // Single word
    regs[3] = 30;
    issue(3, 3);
    wait_done();

    // Wrapping sweep with select checks
    issue(14, 1);
    chk("wrap_sel0_a", 64'(regsel_source0), 64'(14));
    chk("wrap_sel1_a", 64'(regsel_source1), 64'(15));
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_sel0_b", 64'(regsel_source0), 64'(0));
    chk("wrap_sel1_b", 64'(regsel_source1), 64'(1));
    wait_done();

    // Stalls in a 1,0,0,1 ready pattern
    pidx = 0; rdy_mode = 2;
    issue(2, 6);
    wait_done();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Start while busy ignored, start in done cycle honoured
    issue(0, 7);
    @(posedge clk); #1;
    lo_reg = 4'd9; hi_reg = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    issue(4, 5);
    chk_latency();
    wait_done();

    // Reset in SEND1 of a full sweep
    issue(0, 15);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid && out_index == 4'd5) break;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    q.delete(); exp_done = 0; stall_prev = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_busy", 64'(busy), 64'(0));

    // Randomized sweeps
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      rdy_mode = int'($urandom_range(0, 1));
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      wait_done();
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register data width.
REQ-002 Parameter SEL_WIDTH, default 4, SHALL set the register select width (16 registers).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a sweep; sampled only in IDLE.
REQ-006 lo_reg  input  SEL_WIDTH  SHALL give the first register of the sweep; sampled with start.
REQ-007 hi_reg  input  SEL_WIDTH  SHALL give the last register of the sweep; sampled with start.
REQ-008 regsel_source0  output  SEL_WIDTH  SHALL drive the register file read port 0 select.
REQ-009 regsel_source1  output  SEL_WIDTH  SHALL drive the register file read port 1 select.
REQ-010 dataout0  input  DATA_WIDTH  SHALL carry the register file port 0 read data (combinational read).
REQ-011 dataout1  input  DATA_WIDTH  SHALL carry the register file port 1 read data (combinational read).
REQ-012 out_valid  output  1  SHALL flag a valid output word.
REQ-013 out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-014 out_data  output  DATA_WIDTH  SHALL carry the register value.
REQ-015 out_index  output  SEL_WIDTH  SHALL carry the register number of out_data.
REQ-016 out_last  output  1  SHALL mark the final word of the sweep.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.
REQ-018 done  output  1  SHALL pulse high for exactly one cycle after the last word transfers.

Function
REQ-019 States SHALL be IDLE, FETCH, SEND0, SEND1.
REQ-020 IDLE with start=1 SHALL latch ptr=lo_reg, remaining=((hi_reg-lo_reg) mod 16)+1, then enter FETCH.
REQ-021 lo_reg>hi_reg SHALL wrap through 15 to 0 (lo=14, hi=1 -> 14,15,0,1); lo_reg==hi_reg SHALL yield exactly one word.
REQ-022 FETCH SHALL drive regsel_source0=ptr, regsel_source1=(ptr+1) mod 16, capture dataout0/dataout1 into buf0/buf1 at the edge, then enter SEND0 (one cycle in FETCH).
REQ-023 SEND0 SHALL assert out_valid with out_data=buf0, out_index=ptr.
REQ-024 SEND1 SHALL assert out_valid with out_data=buf1, out_index=(ptr+1) mod 16.
REQ-025 Transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1; each transfer decrements remaining by 1.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_index, out_last SHALL hold stable.
REQ-027 Transfer in SEND0 SHALL go to IDLE if remaining was 1, else to SEND1.
REQ-028 Transfer in SEND1 SHALL go to IDLE if remaining was 1, else to FETCH with ptr=(ptr+2) mod 16.
REQ-029 out_last SHALL be high exactly when out_valid=1 and remaining==1.
REQ-030 done SHALL assert in the cycle following the out_last transfer, concurrent with return to IDLE.
REQ-031 start while busy SHALL be ignored; start in the done cycle SHALL begin a new sweep.
REQ-032 Throughput SHALL be 2 words per 3 cycles with out_ready held high; latency start to first out_valid SHALL be 2 cycles.
REQ-033 Register file contents SHALL be sampled per pair at FETCH; writes between FETCHes are visible to later pairs.
REQ-034 In IDLE regsel_source0/1 SHALL hold 0 and out_valid SHALL be 0.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, ptr=0, remaining=0, buf0=buf1=0, without waiting for clk.
REQ-036 During and after reset all outputs SHALL be 0 until the next accepted start.
REQ-037 reset mid-sweep SHALL abort with no further out_valid or done pulse.

Verification
REQ-038 R0..R15 preloaded with 100+n, lo=0, hi=15, out_ready=1 -> 16 words 100..115, indices 0..15, out_last on index 15, one done pulse.
REQ-039 lo=3, hi=3, R3=30 -> single word 30, index 3, out_last=1, done next cycle.
REQ-040 lo=14, hi=1 -> indices 14,15,0,1 in order, selects 14/15 then 0/1.
REQ-041 lo=2, hi=6, out_ready toggled 1,0,0,1 -> no word lost or duplicated, data stable during stall, 5 words.
REQ-042 reset asserted in SEND1 of a 0..15 sweep -> busy=0, out_valid=0 same cycle, no done pulse.
REQ-043 start pulsed while busy -> ignored; start in done cycle -> second sweep begins, first word after 2 cycles.
